// File: rtl/bp_me_pkg.sv
// Shared types for the memory-engine DMA arbiter: FSM state encoding and
// arbitration constants.
package bp_me_pkg;

    typedef enum logic [1:0] {
        e_arb_idle  = 2'd0,
        e_arb_read  = 2'd1,
        e_arb_write = 2'd2
    } dma_arb_state_e;

    localparam int dma_arb_reqs_lp = 2;

    // Beat counter width; a single-beat block still needs one bit.
    function automatic int dma_arb_cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: combinational grant over the current requests, priority
// rotating past the last requestor whose grant was consumed (yumi_i).
module bsg_arb_round_robin #(
    parameter int width_p = 2,
    localparam int lg_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [width_p-1:0]     reqs_i,
    input  logic                   yumi_i,
    output logic [width_p-1:0]     grants_o,
    output logic [lg_width_lp-1:0] grant_id_o
);

    logic [lg_width_lp-1:0] last_q;
    logic                   found;

    always_comb begin
        grants_o   = '0;
        grant_id_o = '0;
        found      = 1'b0;
        for (int i = 1; i <= width_p; i++) begin
            int idx;
            idx = (int'(last_q) + i) % width_p;
            if (!found && reqs_i[idx]) begin
                found         = 1'b1;
                grants_o[idx] = 1'b1;
                grant_id_o    = lg_width_lp'(idx);
            end
        end
    end

    // Reset to the highest index so requestor 0 wins the first tie.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_q <= lg_width_lp'(width_p - 1);
        end else if (yumi_i) begin
            last_q <= grant_id_o;
        end
    end

endmodule

// File: rtl/bp_me_cache_dma_arb.sv
// Two-to-one DMA arbiter between the L2 cache DMA port (req 0) and the bypass
// DMA engine (req 1); one outstanding transaction, data beats routed to its owner.
module bp_me_cache_dma_arb
    import bp_me_pkg::*;
#(
    parameter int addr_width_p  = 40,
    parameter int fill_width_p  = 64,
    parameter int block_width_p = 512,
    localparam int pkt_width_lp = addr_width_p + 1,
    localparam int beats_lp     = block_width_p / fill_width_p,
    localparam int cnt_width_lp = dma_arb_cnt_width(beats_lp)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic [2*pkt_width_lp-1:0] req_pkt_i,
    input  logic [1:0]                req_pkt_v_i,
    output logic [1:0]                req_pkt_ready_and_o,

    input  logic [2*fill_width_p-1:0] req_data_i,
    input  logic [1:0]                req_data_v_i,
    output logic [1:0]                req_data_ready_and_o,

    output logic [2*fill_width_p-1:0] req_data_o,
    output logic [1:0]                req_data_v_o,
    input  logic [1:0]                req_data_ready_and_i,

    output logic [pkt_width_lp-1:0]   dma_pkt_o,
    output logic                      dma_pkt_v_o,
    input  logic                      dma_pkt_ready_and_i,

    input  logic [fill_width_p-1:0]   dma_data_i,
    input  logic                      dma_data_v_i,
    output logic                      dma_data_ready_and_o,

    output logic [fill_width_p-1:0]   dma_data_o,
    output logic                      dma_data_v_o,
    input  logic                      dma_data_ready_and_i
);

    typedef struct packed {
        logic                    write_not_read;
        logic [addr_width_p-1:0] addr;
    } bsg_cache_dma_pkt_s;

    dma_arb_state_e           state_q;
    logic                     owner_q;
    logic [cnt_width_lp-1:0]  cnt_q;

    logic [1:0]               grants;
    logic                     grant_id;
    bsg_cache_dma_pkt_s       grant_pkt;
    logic                     in_idle, in_read, in_write;
    logic                     pkt_hs, beat_hs, last_beat;

    bsg_arb_round_robin #(.width_p(dma_arb_reqs_lp)) arb (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .reqs_i     (req_pkt_v_i),
        .yumi_i     (pkt_hs),
        .grants_o   (grants),
        .grant_id_o (grant_id)
    );

    // Gating with reset_n_i keeps every valid/ready low while reset is held.
    assign in_idle  = reset_n_i && (state_q == e_arb_idle);
    assign in_read  = reset_n_i && (state_q == e_arb_read);
    assign in_write = reset_n_i && (state_q == e_arb_write);

    assign grant_pkt = grant_id ? req_pkt_i[2*pkt_width_lp-1:pkt_width_lp]
                                : req_pkt_i[pkt_width_lp-1:0];

    assign dma_pkt_o           = grant_pkt;
    assign dma_pkt_v_o         = in_idle && (|req_pkt_v_i);
    assign req_pkt_ready_and_o = in_idle ? (grants & {2{dma_pkt_ready_and_i}}) : 2'b00;
    assign pkt_hs              = dma_pkt_v_o && dma_pkt_ready_and_i;

    assign req_data_o           = {2{dma_data_i}};
    assign dma_data_ready_and_o = in_read && req_data_ready_and_i[owner_q];
    assign dma_data_o           = owner_q ? req_data_i[2*fill_width_p-1:fill_width_p]
                                          : req_data_i[fill_width_p-1:0];
    assign dma_data_v_o         = in_write && req_data_v_i[owner_q];

    for (genvar gi = 0; gi < 2; gi++) begin : g_route
        assign req_data_v_o[gi]         = in_read  && (owner_q == 1'(gi)) && dma_data_v_i;
        assign req_data_ready_and_o[gi] = in_write && (owner_q == 1'(gi)) && dma_data_ready_and_i;
    end

    assign beat_hs   = (dma_data_v_i && dma_data_ready_and_o)
                     || (dma_data_v_o && dma_data_ready_and_i);
    assign last_beat = (cnt_q == cnt_width_lp'(beats_lp - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_arb_idle;
            owner_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                e_arb_idle: begin
                    if (pkt_hs) begin
                        owner_q <= grant_id;
                        cnt_q   <= '0;
                        state_q <= grant_pkt.write_not_read ? e_arb_write : e_arb_read;
                    end
                end
                e_arb_read, e_arb_write: begin
                    if (beat_hs) begin
                        if (last_beat) begin
                            cnt_q   <= '0;
                            state_q <= e_arb_idle;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= e_arb_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_me_cache_dma_arb.sv
// Scoreboard bench for the DMA arbiter: stimulus pushes expected handshakes,
// a negedge monitor pops and compares every observed handshake.
module tb_bp_me_cache_dma_arb;

    localparam int A = 40;
    localparam int F = 64;
    localparam int P = A + 1;
    localparam int B = 8;

    logic           clk = 1'b0;
    logic           reset_n_i;
    logic [2*P-1:0] req_pkt_i;
    logic [1:0]     req_pkt_v_i;
    logic [1:0]     req_pkt_ready_and_o;
    logic [2*F-1:0] req_data_i;
    logic [1:0]     req_data_v_i;
    logic [1:0]     req_data_ready_and_o;
    logic [2*F-1:0] req_data_o;
    logic [1:0]     req_data_v_o;
    logic [1:0]     req_data_ready_and_i;
    logic [P-1:0]   dma_pkt_o;
    logic           dma_pkt_v_o;
    logic           dma_pkt_ready_and_i;
    logic [F-1:0]   dma_data_i;
    logic           dma_data_v_i;
    logic           dma_data_ready_and_o;
    logic [F-1:0]   dma_data_o;
    logic           dma_data_v_o;
    logic           dma_data_ready_and_i;

    always #5 clk = ~clk;

    bp_me_cache_dma_arb #(.addr_width_p(A), .fill_width_p(F), .block_width_p(512)) dut (
        .clk_i                (clk),
        .reset_n_i            (reset_n_i),
        .req_pkt_i            (req_pkt_i),
        .req_pkt_v_i          (req_pkt_v_i),
        .req_pkt_ready_and_o  (req_pkt_ready_and_o),
        .req_data_i           (req_data_i),
        .req_data_v_i         (req_data_v_i),
        .req_data_ready_and_o (req_data_ready_and_o),
        .req_data_o           (req_data_o),
        .req_data_v_o         (req_data_v_o),
        .req_data_ready_and_i (req_data_ready_and_i),
        .dma_pkt_o            (dma_pkt_o),
        .dma_pkt_v_o          (dma_pkt_v_o),
        .dma_pkt_ready_and_i  (dma_pkt_ready_and_i),
        .dma_data_i           (dma_data_i),
        .dma_data_v_i         (dma_data_v_i),
        .dma_data_ready_and_o (dma_data_ready_and_o),
        .dma_data_o           (dma_data_o),
        .dma_data_v_o         (dma_data_v_o),
        .dma_data_ready_and_i (dma_data_ready_and_i)
    );

    // kind: 0 = pkt handshake, 1 = read beat to requestor, 2 = write beat to DRAM
    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  idx;
        logic [63:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    function automatic void chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endfunction

    function automatic void expect_ev(input logic [1:0] kind, input logic [1:0] idx, input logic [63:0] data);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    function automatic void observe(input logic [1:0] kind, input logic [1:0] idx, input logic [63:0] data);
        ev_t act;
        ev_t e;
        act.kind = kind;
        act.idx  = idx;
        act.data = data;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected handshake: got %h expected none", act);
        end else begin
            e = exp_q.pop_front();
            chk((kind == 2'd0) ? "pkt" : (kind == 2'd1) ? "rd_beat" : "wr_beat", 72'(act), 72'(e));
        end
    endfunction

    function automatic logic [1:0] rdy_idx(input logic [1:0] r);
        return (r == 2'b01) ? 2'd0 : (r == 2'b10) ? 2'd1 : 2'd3;
    endfunction

    always @(negedge clk) begin
        if (reset_n_i) begin
            if (dma_pkt_v_o && dma_pkt_ready_and_i)
                observe(2'd0, rdy_idx(req_pkt_ready_and_o), 64'(dma_pkt_o));
            for (int i = 0; i < 2; i++)
                if (req_data_v_o[i] && req_data_ready_and_i[i])
                    observe(2'd1, 2'(i), req_data_o[i*F +: F]);
            if (dma_data_v_o && dma_data_ready_and_i)
                observe(2'd2, 2'd0, dma_data_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic quiet();
        req_pkt_v_i          = 2'b00;
        req_data_v_i         = 2'b00;
        req_data_ready_and_i = 2'b00;
        dma_pkt_ready_and_i  = 1'b0;
        dma_data_v_i         = 1'b0;
        dma_data_ready_and_i = 1'b0;
    endtask

    function automatic logic [71:0] all_hs_outs();
        return 72'({dma_pkt_v_o, req_pkt_ready_and_o, req_data_v_o, req_data_ready_and_o,
                    dma_data_v_o, dma_data_ready_and_o});
    endfunction

    // Present a pkt from requestor 'who', check same-cycle pass-through, handshake it.
    task automatic issue_pkt(input int who, input logic [P-1:0] pkt, input string name);
        dma_pkt_ready_and_i = 1'b1;
        settle();
        chk({name, " pkt_o"}, 72'(dma_pkt_o), 72'(pkt));
        chk({name, " grant"}, 72'(req_pkt_ready_and_o), 72'(2'b01 << who));
        expect_ev(2'd0, 2'(who), 64'(pkt));
        tick();
        dma_pkt_ready_and_i = 1'b0;
    endtask

    // Deliver B read beats to 'owner'; optional 3-cycle requestor stall at beat stall_at.
    task automatic read_beats(input int owner, input logic [63:0] base, input int stall_at, input string name);
        req_data_ready_and_i = 2'b11;
        for (int b = 0; b < B; b++) begin
            dma_data_v_i = 1'b1;
            dma_data_i   = base + 64'(b);
            if (b == stall_at) begin
                for (int s = 0; s < 3; s++) begin
                    req_data_ready_and_i[owner] = 1'b0;
                    settle();
                    chk({name, " stall dma_ready"}, 72'(dma_data_ready_and_o), 72'(0));
                    tick();
                end
                req_data_ready_and_i[owner] = 1'b1;
            end
            settle();
            chk({name, " no pkt mid-read"}, 72'({dma_pkt_v_o, req_pkt_ready_and_o}), 72'(0));
            expect_ev(2'd1, 2'(owner), base + 64'(b));
            tick();
        end
        settle();
        chk({name, " idle after last beat"}, 72'({dma_data_ready_and_o, req_data_v_o}), 72'(0));
        dma_data_v_i         = 1'b0;
        req_data_ready_and_i = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int cyc;
        reset_n_i  = 1'b0;
        req_pkt_i  = '0;
        req_data_i = '0;
        dma_data_i = '0;
        quiet();
        req_pkt_v_i = 2'b11;
        settle();
        chk("reset outputs", all_hs_outs(), 72'(0));
        tick();
        tick();
        reset_n_i   = 1'b1;
        req_pkt_v_i = 2'b00;
        tick();

        // Cache read alone
        req_pkt_i[P-1:0] = {1'b0, 40'h80};
        req_pkt_v_i      = 2'b01;
        issue_pkt(0, {1'b0, 40'h80}, "t1");
        req_pkt_v_i = 2'b00;
        read_beats(0, 64'h1000_0000, -1, "t1");

        // Bypass write with toggling DRAM ready; wrong-direction data offered too
        req_pkt_i[2*P-1:P] = {1'b1, 40'h1000};
        req_pkt_v_i        = 2'b10;
        issue_pkt(1, {1'b1, 40'h1000}, "t2");
        req_pkt_v_i = 2'b00;
        b   = 0;
        cyc = 0;
        while (b < B && cyc < 40) begin
            req_data_v_i         = 2'b11;
            req_data_i           = {64'hB000_0000 + 64'(b), 64'hDEAD_0000_0000_0000 + 64'(b)};
            dma_data_ready_and_i = cyc[0];
            dma_data_v_i         = 1'b1;
            settle();
            chk("t2 no read accept", 72'({dma_data_ready_and_o, req_data_v_o}), 72'(0));
            if (dma_data_ready_and_i) begin
                expect_ev(2'd2, 2'd0, 64'hB000_0000 + 64'(b));
                b++;
            end
            cyc++;
            tick();
        end
        chk("t2 beats done", 72'(b), 72'(B));
        dma_data_ready_and_i = 1'b1;
        settle();
        chk("t2 idle after last beat", 72'({req_data_ready_and_o, dma_data_v_o}), 72'(0));
        quiet();

        // Reset with everything asserted, then both requestors contend
        reset_n_i            = 1'b0;
        req_pkt_i            = {1'b0, 40'h300, 1'b0, 40'h200};
        req_pkt_v_i          = 2'b11;
        req_data_v_i         = 2'b11;
        req_data_ready_and_i = 2'b11;
        dma_pkt_ready_and_i  = 1'b1;
        dma_data_v_i         = 1'b1;
        dma_data_ready_and_i = 1'b1;
        settle();
        chk("t3 reset outputs", all_hs_outs(), 72'(0));
        tick();
        reset_n_i = 1'b1;
        quiet();
        req_pkt_v_i = 2'b11;
        for (int t = 0; t < 4; t++) begin
            issue_pkt(t % 2, (t % 2 == 0) ? {1'b0, 40'h200} : {1'b0, 40'h300}, "t3");
            read_beats(t % 2, 64'h3000_0000 + 64'(t * 16), -1, "t3");
        end
        req_pkt_v_i = 2'b00;

        // Requestor backpressure mid-read
        req_pkt_i[P-1:0] = {1'b0, 40'h400};
        req_pkt_v_i      = 2'b01;
        issue_pkt(0, {1'b0, 40'h400}, "t4");
        req_pkt_v_i = 2'b00;
        read_beats(0, 64'h4000_0000, 3, "t4");

        // Reset at beat 3 of a write, then a fresh read from cnt=0
        req_pkt_i[2*P-1:P] = {1'b1, 40'h2000};
        req_pkt_v_i        = 2'b10;
        issue_pkt(1, {1'b1, 40'h2000}, "t5");
        req_pkt_v_i          = 2'b00;
        dma_data_ready_and_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_data_v_i = 2'b10;
            req_data_i   = {64'h5000_0000 + 64'(k), 64'h0};
            expect_ev(2'd2, 2'd0, 64'h5000_0000 + 64'(k));
            tick();
        end
        req_data_v_i = 2'b10;
        reset_n_i    = 1'b0;
        settle();
        chk("t5 reset mid-write", all_hs_outs(), 72'(0));
        tick();
        reset_n_i = 1'b1;
        quiet();
        req_pkt_i   = {1'b1, 40'h600, 1'b0, 40'h500};
        req_pkt_v_i = 2'b11;
        issue_pkt(0, {1'b0, 40'h500}, "t5");
        req_pkt_v_i = 2'b00;
        read_beats(0, 64'h5500_0000, -1, "t5");

        tick();
        chk("scoreboard drained", 72'(exp_q.size()), 72'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
